instr_fetch: RTL
================

Name: instr_fetch

Overview:
- Fetch stage directly downstream of the PC: samples the PC word address, performs a req/ack read of instruction memory and buffers fetched words in a 2-entry queue for decode.
- Back-pressures the PC with pc_stall.
- Discards wrong-path work on a taken branch (flush = SaltoCond & oZero).
- Presents the head instruction with pre-split fields and a sign-extended immediate for the control unit and ALU path.

Parameters:
- ADDR_W, 8, instruction-memory word-address width (256 words, addresses 0..255).
- DATA_W, 32, instruction width.
- Q_DEPTH, 2, fetch queue entries (fixed at 2; other values unsupported).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- pc_addr  in  32  word address from PC.
- pc_stall  out  1  1 = PC must hold its value this cycle.
- flush  in  1  taken branch; kills queued and in-flight fetches.
- mem_req  out  1  memory read request.
- mem_addr  out  ADDR_W  request address.
- mem_ack  in  1  one-cycle pulse, mem_rdata valid.
- mem_rdata  in  DATA_W  fetched word.
- instr_valid  out  1  queue head valid.
- dec_ready  in  1  decode consumes head when instr_valid & dec_ready.
- instr  out  DATA_W  head instruction.
- instr_pc  out  ADDR_W  address of head instruction.
- opcode  out  6  instr[31:26].
- rs, rt, rd  out  5 each  instr[25:21], [20:16], [15:11].
- ext_imm  out  32  sign-extended instr[15:0].
- addr_err  out  1  sticky: accepted pc_addr had nonzero bits [31:ADDR_W].

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, queue empty, mem_req=0, mem_addr=0, addr_err=0.
  - instr_valid=0; instr, instr_pc and all field outputs = 0.
  - A reset during an outstanding request drops mem_req immediately; memory must tolerate the abandoned request.
- FSM states: IDLE, WAIT, DRAIN.
  - IDLE: accept = (queue count < 2) & ~flush. On accept:
    - latch pc_addr[ADDR_W-1:0] into mem_addr and set mem_req=1 at the next edge.
    - go to WAIT.
    - set addr_err if pc_addr[31:ADDR_W] != 0.
  - WAIT: mem_req and mem_addr held stable until mem_ack. mem_ack may arrive in the first cycle mem_req is high.
    - On mem_ack & ~flush: push {mem_addr, mem_rdata}, mem_req=0, go to IDLE.
    - On flush with no ack: go to DRAIN, mem_req stays 1.
    - On flush coinciding with ack: data discarded, go to IDLE.
  - DRAIN: mem_req held until mem_ack; response discarded; mem_req=0, go to IDLE.
- pc_stall = ~(state==IDLE & count<2) | flush (combinational). The PC advances only in the cycle its address is accepted.
- Latency, zero-wait memory:
  - pc_addr accepted at edge N; mem_req high in cycle N+1; ack in N+1; instr_valid in cycle N+2.
  - Peak throughput: 1 instruction per 2 cycles.
- Queue: 2-entry FIFO, head on outputs.
  - Pop on instr_valid & dec_ready.
  - Push and pop in the same cycle: allowed, count unchanged.
  - Push never occurs when full; accept is blocked at count==2.
- flush: at the next edge the queue is emptied and instr_valid=0; a pop in the same cycle is ignored. Next fetch is accepted no earlier than the cycle after flush deasserts; the PC supplies the branch target.
- Field outputs: combinational from head; all 0 when the queue is empty.
- Address wrap: addresses 255 -> 0 are passed through unmodified; no wrap logic in this block.

Decomposition:
- Shared package cpu_pkg:
  - ADDR_W and DATA_W defaults.
  - Fetch state encoding (IDLE=2'd0, WAIT=2'd1, DRAIN=2'd2).
  - Field bit-position constants (OPC_HI=31, OPC_LO=26, RS_HI=25, ...).
- Sub-module fetch_queue:
  - 2-entry FIFO of {ADDR_W+DATA_W} bits with push, pop, clear, count, head.
  - Same clk and active-low async reset.

Test Plan:
- Reset: hold reset=0 with mem_ack=1 and dec_ready=1 -> mem_req=0, instr_valid=0, ext_imm=0, addr_err=0. Release reset, pc_addr=0 -> mem_req=1 with mem_addr=0 one cycle later.
- Streaming, zero-wait memory (mem_rdata=0x20010005 at addr 0, 0x2002FFFC at addr 1), dec_ready=1:
  - instr_valid two cycles after accept.
  - Head 0: opcode=8, rs=0, rt=1, ext_imm=0x00000005.
  - Head 1: ext_imm=0xFFFFFFFC, instr_pc=1.
- Back-pressure: dec_ready=0, 3 addresses offered -> two queued, pc_stall=1, no third mem_req. dec_ready=1 for one cycle -> pop addr 0, third fetch issues.
- Flush in WAIT with 3-cycle memory latency:
  - flush at cycle 1 of wait -> state DRAIN, mem_req held until ack.
  - Data dropped, instr_valid=0.
  - Next accepted pc_addr=0x40 fetched correctly.
- Flush coincident with mem_ack and a pop -> queue empty next cycle, no push, no spurious instr_valid.
- pc_addr=0x00000100 accepted -> mem_addr=0x00, addr_err=1 and remains 1 until reset=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end.
//   - Default widths for the instruction-memory address and instruction word.
//   - Fetch FSM state encoding.
//   - Bit positions of the instruction fields presented to decode.
package cpu_pkg;

  localparam int ADDR_W_DEF  = 8;
  localparam int DATA_W_DEF  = 32;
  localparam int Q_DEPTH_DEF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO holding fetched {address, instruction} pairs.
// Ports:
//   clk, reset      clock and asynchronous active-low reset
//   push, push_data write one entry (never issued when full)
//   pop             remove the head entry (ignored when empty)
//   clear           empty the queue; overrides push and pop
//   count           number of valid entries (0..2)
//   head            oldest entry; contents undefined when count==0
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int ENTRY_W = ADDR_W_DEF + DATA_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_data,
  input  logic               pop,
  input  logic               clear,
  output logic [1:0]         count,
  output logic [ENTRY_W-1:0] head
);

  logic [ENTRY_W-1:0] entry0;
  logic [ENTRY_W-1:0] entry1;
  logic               do_push;
  logic               do_pop;
  logic [1:0]         count_d;

  assign do_push = push & ~clear;
  assign do_pop  = pop & ~clear & (count != 2'd0);
  assign head    = entry0;

  always_comb begin
    count_d = count;
    if (clear) begin
      count_d = 2'd0;
    end else begin
      unique case ({do_push, do_pop})
        2'b10:   count_d = count + 2'd1;
        2'b01:   count_d = count - 2'd1;
        default: count_d = count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= 2'd0;
    end else begin
      count <= count_d;
    end
  end

  // Storage is not reset: consumers qualify head with count.
  always_ff @(posedge clk) begin
    if (do_pop) begin
      if (count == 2'd2) begin
        entry0 <= entry1;
      end
      if (do_push) begin
        // Pop with push: the new word lands right behind whatever survives.
        if (count == 2'd1) begin
          entry0 <= push_data;
        end else begin
          entry1 <= push_data;
        end
      end
    end else if (do_push) begin
      if (count == 2'd0) begin
        entry0 <= push_data;
      end else begin
        entry1 <= push_data;
      end
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage.
// Samples the PC word address, performs a req/ack read of instruction memory,
// buffers fetched words in a 2-entry queue and presents the head instruction
// with pre-split fields and a sign-extended immediate.
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   pc_addr, pc_stall     PC word address in; hold request back to the PC
//   flush                 taken branch: kills queued and in-flight fetches
//   mem_req/addr/ack/rdata instruction-memory read handshake
//   instr_valid, dec_ready queue head valid / decode consumes head
//   instr, instr_pc       head instruction and its address
//   opcode, rs, rt, rd    head fields (0 when queue empty)
//   ext_imm               sign-extended head immediate (0 when queue empty)
//   addr_err              sticky: an accepted pc_addr exceeded ADDR_W bits
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int Q_DEPTH = Q_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       pc_addr,
  output logic              pc_stall,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              instr_valid,
  input  logic              dec_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [5:0]        opcode,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [31:0]       ext_imm,
  output logic              addr_err
);

  if (Q_DEPTH != 2) begin : g_depth_chk
    $error("instr_fetch supports only Q_DEPTH == 2");
  end

  localparam int          ENTRY_W = ADDR_W + DATA_W;
  localparam logic [1:0]  Q_FULL  = 2'(Q_DEPTH);

  function automatic logic signed [31:0] sext16(input logic signed [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  fetch_state_e       state_q;
  fetch_state_e       state_d;
  logic               req_d;
  logic               addr_ld;
  logic               accept;
  logic               q_push;
  logic               q_pop;
  logic [1:0]         q_count;
  logic [ENTRY_W-1:0] q_head;
  logic [DATA_W-1:0]  head_instr;

  assign accept   = (state_q == IDLE) & (q_count < Q_FULL) & ~flush;
  assign pc_stall = ~((state_q == IDLE) & (q_count < Q_FULL)) | flush;

  always_comb begin
    state_d = state_q;
    req_d   = mem_req;
    addr_ld = 1'b0;
    q_push  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = WAIT;
          req_d   = 1'b1;
          addr_ld = 1'b1;
        end
      end
      WAIT: begin
        if (mem_ack) begin
          // A flush coinciding with the ack drops the returned word.
          state_d = IDLE;
          req_d   = 1'b0;
          q_push  = ~flush;
        end else if (flush) begin
          // Request must stay up until memory answers; answer is discarded.
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (mem_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      addr_err <= 1'b0;
    end else begin
      state_q <= state_d;
      mem_req <= req_d;
      if (addr_ld) begin
        mem_addr <= pc_addr[ADDR_W-1:0];
        addr_err <= addr_err | (|pc_addr[31:ADDR_W]);
      end
    end
  end

  assign q_pop = instr_valid & dec_ready;

  fetch_queue #(
    .ENTRY_W (ENTRY_W)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (q_push),
    .push_data ({mem_addr, mem_rdata}),
    .pop       (q_pop),
    .clear     (flush),
    .count     (q_count),
    .head      (q_head)
  );

  // Head outputs are forced to zero while the queue is empty.
  assign instr_valid = (q_count != 2'd0);
  assign head_instr  = instr_valid ? q_head[DATA_W-1:0] : '0;
  assign instr       = head_instr;
  assign instr_pc    = instr_valid ? q_head[ENTRY_W-1:DATA_W] : '0;
  assign opcode      = head_instr[OPC_HI:OPC_LO];
  assign rs          = head_instr[RS_HI:RS_LO];
  assign rt          = head_instr[RT_HI:RT_LO];
  assign rd          = head_instr[RD_HI:RD_LO];
  assign ext_imm     = sext16(head_instr[IMM_HI:IMM_LO]);

endmodule
